// File: rtl/bcd_sevseg_counter.sv
// rtl/bcd_sevseg_counter.sv - multi-digit BCD up/down counter with tick prescaler and muxed seven-segment driver
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits on seg.
module bcd_sevseg_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 12_500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  carry,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [TW-1:0]         presc;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   next_count;
    logic [4*DIGITS-1:0]   load_clean;
    logic                  wrap;
    logic                  step_c;
    logic [3:0]            step_d;
    logic [3:0]            cur_digit;
    logic                  cur_blank;
    logic [DIGITS-1:0]     blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    assign tick = (presc == TICK_LAST);

    // Ripple BCD step: the carry/borrow propagates only while digits wrap.
    always_comb begin
        next_count = count;
        step_c     = 1'b1;
        step_d     = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            step_d = count[4*i +: 4];
            if (step_c) begin
                if (up) begin
                    if (step_d == 4'd9) begin
                        step_d = 4'd0;
                    end else begin
                        step_d = step_d + 4'd1;
                        step_c = 1'b0;
                    end
                end else begin
                    if (step_d == 4'd0) begin
                        step_d = 4'd9;
                    end else begin
                        step_d = step_d - 4'd1;
                        step_c = 1'b0;
                    end
                end
            end
            next_count[4*i +: 4] = step_d;
        end
        wrap = step_c;
    end

    always_comb begin
        load_clean = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lz;

    // A digit is blank when it and every higher digit are zero; digit 0 never blanks.
    always_comb begin
        blank = '0;
        lz    = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz       = lz & (count[4*i +: 4] == 4'd0);
            blank[i] = lz;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit = count[4*i +: 4];
                cur_blank = blank[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            count    <= '0;
            carry    <= 1'b0;
            scan_cnt <= '0;
            idx      <= '0;
            dig_sel  <= DIGITS'(1);
            seg      <= 7'h3F;
        end else begin
            carry <= 1'b0;
            if (load) begin
                count <= load_clean;
                presc <= '0;
            end else begin
                presc <= tick ? '0 : presc + TW'(1);
                if (tick && en) begin
                    count <= next_count;
                    carry <= wrap;
                end
            end

            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end

            dig_sel <= DIGITS'(1) << idx;
            seg     <= cur_blank ? 7'h00 : decode(cur_digit);
        end
    end

endmodule

// File: tb/tb_bcd_sevseg_counter.sv
// tb/tb_bcd_sevseg_counter.sv - scoreboard bench for bcd_sevseg_counter (DIGITS=2, TICK_DIV=4, SCAN_DIV=2)
module tb_bcd_sevseg_counter;

    localparam int D  = 2;
    localparam int TD = 4;
    localparam int SD = 2;
    localparam int W  = 4 * D;
    localparam int MAXV = 99;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           up = 1'b1;
    logic           load = 1'b0;
    logic [W-1:0]   load_val = '0;
    logic [W-1:0]   count;
    logic           tick;
    logic           carry;
    logic [6:0]     seg;
    logic [D-1:0]   dig_sel;

    bcd_sevseg_counter #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count), .tick(tick), .carry(carry), .seg(seg), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] want;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;

    int mc = 0, mp = 0, ms = 0, mi = 0;
    logic mcarry = 1'b0;
    logic [D-1:0] mdsel = 1;
    logic [6:0] mseg = 7'h3F;

    function automatic logic [6:0] dec(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        return r;
    endfunction

    function automatic int from_load(input logic [W-1:0] lv);
        int r;
        logic [3:0] nib;
        r = 0;
        for (int i = 0; i < D; i++) begin
            nib = lv[4*i +: 4];
            if (nib <= 4'd9) r += int'(nib) * (10 ** i);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] want);
        exp_t e;
        e.tag  = tag;
        e.want = want;
        sbq.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk(e.tag, obs, e.want);
        end
    endtask

    // Advance one clock: update the reference model from the inputs seen at the edge,
    // queue the expected outputs, then compare at the following falling edge.
    task automatic cycle();
        int digit;
        logic blank;
        @(posedge clk);
        if (rst) begin
            ms = 0; mi = 0; mdsel = 1; mseg = 7'h3F;
            mc = 0; mp = 0; mcarry = 1'b0;
        end else begin
            mdsel = '0;
            mdsel[mi] = 1'b1;
            digit = (mc / (10 ** mi)) % 10;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (mi > 0) && (mc < 10 ** mi);
`else
            blank = 1'b0;
`endif
            mseg = blank ? 7'h00 : dec(digit);
            if (ms == SD - 1) begin
                ms = 0;
                mi = (mi == D - 1) ? 0 : mi + 1;
            end else begin
                ms++;
            end
            mcarry = 1'b0;
            if (load) begin
                mc = from_load(load_val);
                mp = 0;
            end else if (mp == TD - 1) begin
                mp = 0;
                if (en) begin
                    if (up) begin
                        mcarry = (mc == MAXV);
                        mc = (mc == MAXV) ? 0 : mc + 1;
                    end else begin
                        mcarry = (mc == 0);
                        mc = (mc == 0) ? MAXV : mc - 1;
                    end
                end
            end else begin
                mp++;
            end
        end
        sb_push("count", 32'(to_bcd(mc)));
        sb_push("tick", 32'(mp == TD - 1));
        sb_push("carry", 32'(mcarry));
        sb_push("dig_sel", 32'(mdsel));
        sb_push("seg", 32'(mseg));
        @(negedge clk);
        sb_check(32'(count));
        sb_check(32'(tick));
        sb_check(32'(carry));
        sb_check(32'(dig_sel));
        sb_check(32'(seg));
    endtask

    initial begin
        int ticks;

        rst = 1'b1;
        repeat (3) cycle();
        chk("rst_count", 32'(count), 32'h00);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_dig_sel", 32'(dig_sel), 32'b01);
        chk("rst_seg", 32'(seg), 32'h3F);

        rst = 1'b0; en = 1'b1; up = 1'b1;
        repeat (40) cycle();
        chk("ten_ticks", 32'(count), 32'h10);

        en = 1'b0;
        ticks = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (tick) ticks++;
        end
        chk("tick_en0", 32'(ticks), 32'd2);
        chk("hold_en0", 32'(count), 32'h10);

        load_val = 8'h37; load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        chk("load_37", 32'(count), 32'h37);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_mid", 32'(count), 32'h00);

        en = 1'b1; up = 1'b1; load_val = 8'h99; load = 1'b1;
        cycle();
        load = 1'b0;
        repeat (3) cycle();
        chk("pre_wrap_carry", 32'(carry), 32'd0);
        cycle();
        chk("wrap_up_count", 32'(count), 32'h00);
        chk("wrap_up_carry", 32'(carry), 32'd1);
        cycle();
        chk("carry_one_cycle", 32'(carry), 32'd0);

        up = 1'b0; load_val = 8'h00; load = 1'b1;
        cycle();
        load = 1'b0;
        repeat (3) cycle();
        cycle();
        chk("wrap_dn_count", 32'(count), 32'h99);
        chk("wrap_dn_carry", 32'(carry), 32'd1);

        up = 1'b1; load_val = 8'hA3; load = 1'b1;
        cycle();
        load = 1'b0;
        chk("load_sanitize", 32'(count), 32'h03);
        repeat (3) cycle();
        chk("tick_before_load", 32'(tick), 32'd1);
        load_val = 8'h25; load = 1'b1;
        cycle();
        load = 1'b0;
        chk("load_beats_tick", 32'(count), 32'h25);
        chk("load_no_carry", 32'(carry), 32'd0);
        repeat (2) cycle();
        chk("no_early_tick", 32'(tick), 32'd0);
        cycle();
        chk("tick_after_load", 32'(tick), 32'd1);

        en = 1'b0; load_val = 8'h47; load = 1'b1;
        cycle();
        load = 1'b0;
        repeat (8) cycle();

        load_val = 8'h05; load = 1'b1;
        cycle();
        load = 1'b0;
        repeat (6) cycle();
        load_val = 8'h00; load = 1'b1;
        cycle();
        load = 1'b0;
        repeat (6) cycle();

        en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            up = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 7) == 0);
            load_val = W'($urandom);
            cycle();
        end
        load = 1'b0;
        repeat (4) cycle();

        chk("sb_leftover", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
